// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Bit counter width for a WIDTH-bit operation; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the entire arithmetic datapath of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full_adder over WIDTH cycles, LSB first,
// with a start/busy/done handshake around each operation.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one operand bit pair added per cycle, cnt counts 0..WIDTH-1
// DONE  | single cycle, done=1, sum/cout hold the new result
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_t        state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum, fa_carry;
  logic             load, step, finish;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh  <= op_a;
      b_sh  <= op_b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
      carry  <= fa_carry;
      // Counter parks at its last value instead of wrapping past WIDTH-1.
      cnt    <= finish ? cnt : cnt + 1'b1;
    end
  end

  // Result registers only move on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (finish) begin
      sum  <= {fa_sum, res_sh[WIDTH-1:1]};
      cout <= fa_carry;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input string nm);
    int lat;
    bit hold_ok;
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom_range(255, 0);
    op_b  = $urandom_range(255, 0);
    cin   = $urandom_range(1, 0);
    check({nm, " busy_after_start"}, busy, 1);
    lat     = 0;
    hold_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (sum !== prev_sum || cout !== prev_cout) hold_ok = 1'b0;
    end
    check({nm, " latency"}, lat, 9);
    check({nm, " hold_prev"}, hold_ok, 1);
    check({nm, " sum"}, sum, es);
    check({nm, " cout"}, cout, ec);
    @(negedge clk);
    check({nm, " done_width"}, done, 0);
    check({nm, " idle_after"}, busy, 0);
    prev_sum  = es;
    prev_cout = ec;
  endtask

  initial begin
    int lat;
    int pulses;
    bit no_done;
    logic [W:0] model;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    #22;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
    end

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum, vecs[i].exp_cout,
             $sformatf("vec%0d", i));

    // Second start during RUN must be ignored.
    op_a  = 8'h03;
    op_b  = 8'h04;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat    = 0;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) begin
        op_a  = 8'hF0;
        op_b  = 8'hF0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (lat == 0) lat = i;
        check("ignore sum", sum, 8'h07);
        check("ignore cout", cout, 0);
      end
    end
    start = 1'b0;
    check("ignore latency", lat, 9);
    check("ignore pulses", pulses, 1);
    prev_sum  = 8'h07;
    prev_cout = 1'b0;

    // Reset in the middle of RUN.
    op_a  = 8'hFF;
    op_b  = 8'hFF;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    no_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) no_done = 1'b0;
    end
    check("abort no_done", no_done, 1);
    check("abort idle", busy, 0);
    prev_sum  = '0;
    prev_cout = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post_reset");

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom_range(255, 0);
      rb = $urandom_range(255, 0);
      rc = $urandom_range(1, 0);
      model = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      run_op(ra, rb, rc, model[W-1:0], model[W], "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
